// File: rtl/imem_fetch_ctrl_if.sv
// Fetch, loader and byte-memory signals shared between the fetch controller,
// the PC/fetch stage, the program loader and the instruction memory.
interface imem_fetch_ctrl_if #(
   parameter int WAD        = 16,
   parameter int WD         = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  fetch_req;
   logic [DATA_WIDTH-1:0] fetch_addr;
   logic                  fetch_ready;
   logic [DATA_WIDTH-1:0] instr;
   logic                  instr_valid;

   logic                  load_valid;
   logic [WAD-1:0]        load_addr;
   logic [WD-1:0]         load_data;
   logic                  load_ready;

   logic [WAD-1:0]        mem_addr;
   logic                  mem_we;
   logic [WD-1:0]         mem_wdata;
   logic [WD-1:0]         mem_rdata;

   modport slave (
      input  fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      output fetch_ready, instr, instr_valid, load_ready, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      input  fetch_ready, instr, instr_valid, load_ready, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Serialises a 32-bit instruction fetch into four byte reads (MSB first) and
// arbitrates the single memory port between fetch and the program loader.
module imem_fetch_ctrl #(
   parameter int WAD        = 16,
   parameter int WD         = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   imem_fetch_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   localparam logic GRANT_LOAD  = 1'b0;
   localparam logic GRANT_FETCH = 1'b1;

   state_t                state_reg;
   logic [1:0]            cnt_reg;
   logic [WAD-1:0]        base_reg;
   logic [DATA_WIDTH-1:0] shreg_reg;
   logic [DATA_WIDTH-1:0] instr_reg;
   logic                  instr_valid_reg;
   logic                  last_grant_reg;

   logic                  grant_fetch;
   logic                  grant_load;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^bus.fetch_addr[DATA_WIDTH-1:WAD];

   // Ties go to whichever side was not granted most recently.
   always_comb begin
      grant_fetch = 1'b0;
      grant_load  = 1'b0;
      if (state_reg == IDLE && !rst) begin
         if (bus.fetch_req && (!bus.load_valid || last_grant_reg == GRANT_LOAD))
            grant_fetch = 1'b1;
         else if (bus.load_valid)
            grant_load = 1'b1;
      end
   end

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      if (grant_load) begin
         bus.mem_addr  = bus.load_addr;
         bus.mem_we    = 1'b1;
         bus.mem_wdata = bus.load_data;
      end else if (state_reg == ISSUE) begin
         bus.mem_addr = base_reg + WAD'(cnt_reg);
      end
   end

   assign bus.fetch_ready = grant_fetch;
   assign bus.load_ready  = grant_load;
   assign bus.instr       = instr_reg;
   assign bus.instr_valid = instr_valid_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         cnt_reg         <= 2'd0;
         base_reg        <= '0;
         shreg_reg       <= '0;
         instr_reg       <= '0;
         instr_valid_reg <= 1'b0;
         last_grant_reg  <= GRANT_LOAD;
      end else begin
         instr_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_fetch) begin
                  base_reg       <= bus.fetch_addr[WAD-1:0];
                  cnt_reg        <= 2'd0;
                  state_reg      <= ISSUE;
                  last_grant_reg <= GRANT_FETCH;
               end else if (grant_load) begin
                  last_grant_reg <= GRANT_LOAD;
               end
            end
            ISSUE: begin
               // Read data lags its address by one cycle, so cnt=0 has nothing to capture.
               if (cnt_reg != 2'd0)
                  shreg_reg <= {shreg_reg[DATA_WIDTH-WD-1:0], bus.mem_rdata};
               cnt_reg <= cnt_reg + 2'd1;
               if (cnt_reg == 2'd3)
                  state_reg <= DRAIN;
            end
            DRAIN: begin
               instr_reg       <= {shreg_reg[DATA_WIDTH-WD-1:0], bus.mem_rdata};
               instr_valid_reg <= 1'b1;
               state_reg       <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a byte-wide synchronous-read memory model.
module tb_imem_fetch_ctrl;
   localparam int WAD = 16;
   localparam int WD  = 8;
   localparam int DW  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl_if #(.WAD(WAD), .WD(WD), .DATA_WIDTH(DW)) bus ();

   imem_fetch_ctrl #(.WAD(WAD), .WD(WD), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [0:65535];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] a, input logic [7:0] d);
      bus.load_valid = 1'b1;
      bus.load_addr  = a;
      bus.load_data  = d;
      @(negedge clk);
      chk("load_ready", bus.load_ready, 1);
      chk("load_we", bus.mem_we, 1);
      chk("load_addr", bus.mem_addr, a);
      chk("load_wdata", bus.mem_wdata, d);
      chk("load_no_valid", bus.instr_valid, 0);
      tick();
      bus.load_valid = 1'b0;
   endtask

   // Leaves the caller at the negedge of T+6 after the result checks.
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      @(negedge clk);
      chk("fetch_accept", bus.fetch_ready, 1);
      chk("fetch_accept_noload", bus.load_ready, 0);
      tick();
      bus.fetch_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("busy_valid", bus.instr_valid, 0);
         chk("busy_load_ready", bus.load_ready, 0);
         chk("busy_we", bus.mem_we, 0);
         chk("busy_fetch_ready", bus.fetch_ready, 0);
         if (i < 4) chk("issue_addr", bus.mem_addr, 32'((a + 32'(i)) & 32'hFFFF));
         tick();
      end
      @(negedge clk);
      chk("done_valid", bus.instr_valid, 1);
      chk("done_instr", bus.instr, exp);
   endtask

   initial begin
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.load_valid = 1'b0;
      bus.load_addr  = '0;
      bus.load_data  = '0;

      // Reset state, with both requesters active to show nothing is granted
      bus.fetch_req  = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_addr  = 16'h0055;
      bus.load_data  = 8'h77;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_instr", bus.instr, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_fetch_ready", bus.fetch_ready, 0);
      chk("rst_load_ready", bus.load_ready, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      @(posedge clk);
      #1;
      bus.fetch_req  = 1'b0;
      bus.load_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_addr", bus.mem_addr, 0);
      chk("idle_we", bus.mem_we, 0);
      tick();

      // Load a program word and fetch it
      load(16'h0000, 8'h13);
      load(16'h0001, 8'h05);
      load(16'h0002, 8'h50);
      load(16'h0003, 8'h00);
      do_fetch(32'h0000_0000, 32'h1305_5000);
      tick();
      @(negedge clk);
      chk("after_valid", bus.instr_valid, 0);
      chk("after_instr_hold", bus.instr, 32'h1305_5000);
      tick();

      // Address wrap at the top of memory
      load(16'hFFFE, 8'hAA);
      load(16'hFFFF, 8'hBB);
      load(16'h0000, 8'hCC);
      load(16'h0001, 8'hDD);
      do_fetch(32'h0000_FFFE, 32'hAABB_CCDD);
      tick();

      // Loader held through a fetch is served in the first IDLE cycle
      load(16'h0004, 8'h11);
      load(16'h0005, 8'h22);
      load(16'h0006, 8'h33);
      load(16'h0007, 8'h44);
      load(16'h0008, 8'h55);
      load(16'h0009, 8'h66);
      load(16'h000A, 8'h77);
      load(16'h000B, 8'h88);
      bus.load_valid = 1'b1;
      bus.load_addr  = 16'h0020;
      bus.load_data  = 8'h5A;
      do_fetch(32'h0000_0004, 32'h1122_3344);
      chk("held_load_ready", bus.load_ready, 1);
      chk("held_load_we", bus.mem_we, 1);
      chk("held_load_addr", bus.mem_addr, 32'h0020);
      tick();
      bus.load_valid = 1'b0;

      // Reset in the middle of a fetch
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0008;
      @(negedge clk);
      chk("midrst_accept", bus.fetch_ready, 1);
      tick();
      bus.fetch_req = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_instr", bus.instr, 0);
      chk("midrst_valid", bus.instr_valid, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("midrst_no_pulse", bus.instr_valid, 0);
         tick();
      end

      // Tie straight after reset: fetch, then loader, then fetch
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0008;
      bus.load_valid = 1'b1;
      bus.load_addr  = 16'h0030;
      bus.load_data  = 8'h99;
      @(negedge clk);
      chk("tie1_fetch", bus.fetch_ready, 1);
      chk("tie1_load", bus.load_ready, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("tie_busy_load", bus.load_ready, 0);
         chk("tie_busy_fetch", bus.fetch_ready, 0);
         tick();
      end
      @(negedge clk);
      chk("tie_valid", bus.instr_valid, 1);
      chk("tie_instr", bus.instr, 32'h5566_7788);
      chk("tie2_load", bus.load_ready, 1);
      chk("tie2_fetch", bus.fetch_ready, 0);
      tick();
      @(negedge clk);
      chk("tie3_fetch", bus.fetch_ready, 1);
      chk("tie3_load", bus.load_ready, 0);
      chk("tie3_valid", bus.instr_valid, 0);
      tick();
      bus.fetch_req  = 1'b0;
      bus.load_valid = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      chk("tie3_done_valid", bus.instr_valid, 1);
      chk("tie3_done_instr", bus.instr, 32'h5566_7788);
      tick();

      // Back-to-back fetches with fetch_req held
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0004;
      @(negedge clk);
      chk("b2b_accept1", bus.fetch_ready, 1);
      tick();
      bus.fetch_addr = 32'h0000_0008;
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         chk("b2b_wait1_ready", bus.fetch_ready, 0);
         chk("b2b_wait1_valid", bus.instr_valid, 0);
         tick();
      end
      @(negedge clk);
      chk("b2b_accept2", bus.fetch_ready, 1);
      chk("b2b_valid1", bus.instr_valid, 1);
      chk("b2b_instr1", bus.instr, 32'h1122_3344);
      tick();
      bus.fetch_req = 1'b0;
      for (int i = 7; i < 12; i++) begin
         @(negedge clk);
         chk("b2b_wait2_valid", bus.instr_valid, 0);
         chk("b2b_hold", bus.instr, 32'h1122_3344);
         tick();
      end
      @(negedge clk);
      chk("b2b_valid2", bus.instr_valid, 1);
      chk("b2b_instr2", bus.instr, 32'h5566_7788);
      tick();
      @(negedge clk);
      chk("b2b_pulse_end", bus.instr_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
